pattern_1001_mealy_detector: RTL and testbench
==============================================

// Module: pattern_1001_mealy_detector
// PURPOSE
//  Serial-bit detector for the pattern 1-0-0-1, Mealy style, overlapping matches allowed.
//  Consumes one qualified bit per clock (valid=1) and pulses out in the same cycle the final '1' is presented.
//  Sits on a serial data path behind any bit source providing a valid strobe.
// PARAMETERS
//  CNT_W   16   width of the optional hit counter (used only when PATTERN_HIT_COUNT_EN defined)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  rst        in   1      reset, synchronous, active-high
//  in         in   1      serial data bit, sampled only when valid=1
//  valid      in   1      qualifies in for this cycle
//  out        out  1      Mealy match flag: 1 when the current bit completes 1001
//  hit_count  out  CNT_W  matches since reset (only with PATTERN_HIT_COUNT_EN)
// BEHAVIOUR
//  - State register 5-bit one-hot: S_R=00001, S_1=00010, S_10=00100, S_100=01000, S_1001=10000.
//  - rst=1 at posedge: state<=S_R. out forced 0 while rst=1 regardless of state/inputs.
//  - valid=0: state holds, out=0, in ignored (X on in tolerated).
//  - Transitions on valid=1 (in=0 / in=1):
//      S_R    -> S_R  / S_1
//      S_1    -> S_10 / S_1
//      S_10   -> S_100/ S_1
//      S_100  -> S_R  / S_1001 (out=1 this cycle)
//      S_1001 -> S_10 / S_1   (trailing '1' reused as leading '1' of next match)
//  - out = !rst & valid & in & (state==S_100); purely combinational from state + inputs, zero latency.
//  - Any non-one-hot/illegal state -> S_R on next clock, out=0.
//  - Stream 1001001 gives two pulses (bits 4 and 7); out returns to 0 between them.
//  - Reset mid-sequence discards partial progress; next match needs a full 1001 after rst drops.
// CONFIGURATION
//  - Macro PATTERN_HIT_COUNT_EN:
//    defined: hit_count register, reset to 0 synchronously, increments by 1 on each clock with out=1,
//             saturates at all-ones (no wrap).
//    undefined: hit_count port and counter logic absent; detector behaviour otherwise identical.
// STRUCTURE
//  - Package pattern_pkg: one-hot state localparams/typedef (S_R..S_1001), state width 5, CNT_W default.
//  - Top: next-state logic, state register, Mealy output decode.
//  - Optional sub-module pattern_hit_counter (CNT_W, clk, rst, inc, count), instantiated only under
//    PATTERN_HIT_COUNT_EN.
// TESTING
//  1. rst=1 two cycles, valid=0 -> state=S_R, out=0; then valid=1 in 1,0,0,1 -> out=1 only on 4th bit.
//  2. valid=1 stream 1,0,0,1,0,0,1 -> out=1 on bits 4 and 7 (overlap), 0 elsewhere.
//  3. 1,0,valid=0 x3 cycles (in toggling),0,1 -> gaps ignored, out=1 on final qualified 1.
//  4. 1,0,0 then rst=1 one cycle, then 1 -> out=0; following 0,0,1 -> out=1.
//  5. 1,1,0,1,0,0,0,1 -> no match (out stays 0); 0,1 appended after 1,0,0,1 ending -> no extra pulse.
//  6. PATTERN_HIT_COUNT_EN, 500 random valid bits -> hit_count equals reference-model match count;
//     with CNT_W=2 and 5 matches -> hit_count=3 (saturated).

Source files
------------

// File: rtl/pattern_1001_mealy_detector_pkg.sv
// Shared types for the 1001 Mealy detector: one-hot state encoding and the default hit-counter width.
package pattern_pkg;

    localparam int unsigned STATE_W       = 5;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [STATE_W-1:0] {
        S_R    = 5'b00001,
        S_1    = 5'b00010,
        S_10   = 5'b00100,
        S_100  = 5'b01000,
        S_1001 = 5'b10000
    } state_t;

endpackage

// File: rtl/pattern_1001_mealy_detector_hit_counter.sv
// Saturating match counter for the 1001 detector; only compiled in when PATTERN_HIT_COUNT_EN is defined.
`ifdef PATTERN_HIT_COUNT_EN
module pattern_hit_counter
    import pattern_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    // Holds at all-ones rather than wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/pattern_1001_mealy_detector.sv
// Serial 1-0-0-1 Mealy detector with overlapping matches on a valid-qualified bit stream.
// Optional saturating hit counter enabled by macro PATTERN_HIT_COUNT_EN.
module pattern_1001_mealy_detector
    import pattern_pkg::*;
`ifdef PATTERN_HIT_COUNT_EN
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             valid,
    output logic             out
`ifdef PATTERN_HIT_COUNT_EN
   ,output logic [CNT_W-1:0] hit_count
`endif
);

    state_t state_q, state_d;

    // Illegal encodings fall to the default arm and recover to S_R, valid or not.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_R:    if (valid) state_d = in ? S_1    : S_R;
            S_1:    if (valid) state_d = in ? S_1    : S_10;
            S_10:   if (valid) state_d = in ? S_1    : S_100;
            S_100:  if (valid) state_d = in ? S_1001 : S_R;
            S_1001: if (valid) state_d = in ? S_1    : S_10;
            default:           state_d = S_R;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_R;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = !rst && valid && in && (state_q == S_100);

`ifdef PATTERN_HIT_COUNT_EN
    pattern_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (out),
        .count (hit_count)
    );
`endif

endmodule

// File: tb/tb_pattern_1001_mealy_detector.sv
// Directed and random checks for the 1001 Mealy detector, including hit counter saturation when enabled.
module tb_pattern_1001_mealy_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic valid = 1'b0;
    logic out;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    logic [3:0] hist;

`ifdef PATTERN_HIT_COUNT_EN
    logic [15:0] hit_count;
    logic        out2;
    logic [1:0]  hit_count2;

    pattern_1001_mealy_detector #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in(in), .valid(valid), .out(out), .hit_count(hit_count)
    );
    pattern_1001_mealy_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(in), .valid(valid), .out(out2), .hit_count(hit_count2)
    );
`else
    pattern_1001_mealy_detector dut (
        .clk(clk), .rst(rst), .in(in), .valid(valid), .out(out)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present one bit between edges and check the combinational output before the next posedge.
    task automatic step(input logic v, input logic b, input logic e, input string tag);
        @(negedge clk);
        rst = 1'b0; valid = v; in = b;
        #1;
        check(tag, {31'b0, out}, {31'b0, e});
`ifdef PATTERN_HIT_COUNT_EN
        check({tag, "_cnt"}, {16'b0, hit_count}, exp_hits);
        check({tag, "_cnt2"}, {30'b0, hit_count2}, (exp_hits > 3) ? 3 : exp_hits);
        check({tag, "_out2"}, {31'b0, out2}, {31'b0, e});
`endif
        if (e) exp_hits++;
    endtask

    task automatic reset_cycles(input logic v, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; valid = v; in = b;
            #1;
            check("rst_out", {31'b0, out}, 32'd0);
        end
        exp_hits = 0;
        hist = 4'b0;
    endtask

    // bits/exps are listed first-bit-first in the low n positions, MSB-aligned at n-1.
    task automatic run(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exps);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], exps[i], tag);
        end
    endtask

    initial begin
        hist = 4'b0;

        // 1: reset with valid low, then a single match on the fourth bit
        reset_cycles(1'b0, 1'b0, 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state", {27'b0, dut.state_q}, 32'h1);
        check("rst_idle_out", {31'b0, out}, 32'd0);
        run("t1", 4, 16'b1001, 16'b0001);

        // 2: overlapping matches
        reset_cycles(1'b0, 1'b0, 1);
        run("t2", 7, 16'b1001001, 16'b0001001);

        // 3: bubbles with toggling data are ignored
        reset_cycles(1'b0, 1'b0, 1);
        run("t3a", 2, 16'b10, 16'b00);
        step(1'b0, 1'b1, 1'b0, "t3_gap");
        step(1'b0, 1'b0, 1'b0, "t3_gap");
        step(1'b0, 1'b1, 1'b0, "t3_gap");
        run("t3b", 2, 16'b01, 16'b01);

        // 4: reset while in S_100 with a qualified 1 must not fire and must discard progress
        reset_cycles(1'b0, 1'b0, 1);
        run("t4a", 3, 16'b100, 16'b000);
        reset_cycles(1'b1, 1'b1, 1);
        run("t4b", 4, 16'b1001, 16'b0001);

        // 5: near misses, then no extra pulse after a match followed by 0,1
        reset_cycles(1'b0, 1'b0, 1);
        run("t5a", 8, 16'b11010001, 16'b00000000);
        run("t5b", 6, 16'b100101, 16'b000100);

        // Five back-to-back overlapping matches (saturates a 2-bit counter)
        reset_cycles(1'b0, 1'b0, 1);
        run("sat", 16, 16'b1001001001001001, 16'b0001001001001001);
        step(1'b0, 1'b0, 1'b0, "sat_idle");
        check("sat_total", exp_hits, 32'd5);

        // Random qualified stream against a 4-bit history model
        reset_cycles(1'b0, 1'b0, 1);
        for (int i = 0; i < 500; i++) begin
            logic v, b, e;
            v = ($urandom_range(0, 3) != 0);
            b = $urandom_range(0, 1) == 1;
            e = v && ({hist[2:0], b} == 4'b1001);
            step(v, b, e, "rand");
            if (v) hist = {hist[2:0], b};
        end
        step(1'b0, 1'b0, 1'b0, "rand_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
